// File: rtl/sync_debounce.sv
// Conditions one raw asynchronous input: synchronizer, consecutive-sample debounce filter, registered edge detect.
// Clean step reaches level after SYNC_STAGES+DEBOUNCE_CYCLES clk edges; no flow control, the input is sampled every cycle.
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("sync_debounce: SYNC_STAGES must be 2 or more");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
      $error("sync_debounce: DEBOUNCE_CYCLES must be 1 or more");
    end
  endgenerate

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   level_nxt;
  logic                   rise_nxt;
  logic                   fall_nxt;
  state_t                 state;

  // Plain shift chain: nothing may sit between these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // The filter state is carried entirely by the counter value.
  assign state = (cnt == '0) ? STABLE : CHECK;

  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE: begin
        if (sync_out != level) begin
          if (DEBOUNCE_CYCLES == 1) begin
            level_nxt = sync_out;
            rise_nxt  = sync_out;
            fall_nxt  = ~sync_out;
          end else begin
            cnt_nxt = CNT_W'(1);
          end
        end
      end
      CHECK: begin
        if (sync_out == level) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          level_nxt = ~level;
          rise_nxt  = ~level;
          fall_nxt  = level;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      level      <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= (cnt_nxt != '0);
    end
  end

  a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(rise_pulse && fall_pulse));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CNT_LAST);

  a_busy_tracks_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (cnt != '0));

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: fixed vector tables, hand-built corner sequences and a randomized run
// compared against a sliding-window model of the filter.
module tb_sync_debounce;

  localparam int S = 2;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  logic async_in;
  logic a6;
  logic level, rise_pulse, fall_pulse, busy;
  logic level6, rise6, fall6, busy6;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: raw samples still inside the synchronizer, and the last D samples seen by the filter.
  bit hist[$];
  bit win[$];
  bit m_level, m_rise, m_fall, m_busy;

  typedef struct {
    bit a;
    bit lvl;
    bit rise;
    bit fall;
    bit busy;
  } vec_t;

  sync_debounce #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (async_in),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  sync_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (a6),
    .level      (level6),
    .rise_pulse (rise6),
    .fall_pulse (fall6),
    .busy       (busy6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(bit a, bit l, bit r, bit f, bit b);
    vec_t v;
    v.a    = a;
    v.lvl  = l;
    v.rise = r;
    v.fall = f;
    v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    win.delete();
    repeat (S) hist.push_back(1'b0);
    repeat (D) win.push_back(1'b0);
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_busy  = 1'b0;
  endtask

  // Level flips once the last D filtered samples all disagree with it.
  task automatic model_step(input bit a);
    bit filt;
    bit all_diff;
    filt = hist.pop_front();
    hist.push_back(a);
    void'(win.pop_front());
    win.push_back(filt);
    all_diff = 1'b1;
    foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (all_diff) begin
      m_level = ~m_level;
      m_rise  = m_level;
      m_fall  = ~m_level;
    end
    m_busy = (filt != m_level);
  endtask

  task automatic tick(input bit a, input bit b6);
    async_in = a;
    a6       = b6;
    @(posedge clk);
    model_step(a);
    #1;
    chk("model.level", level, m_level);
    chk("model.rise",  rise_pulse, m_rise);
    chk("model.fall",  fall_pulse, m_fall);
    chk("model.busy",  busy, m_busy);
  endtask

  task automatic run_table(input vec_t t[$], input bit on6, input string name);
    foreach (t[i]) begin
      if (on6) begin
        tick(async_in, t[i].a);
        chk($sformatf("%s[%0d].level", name, i), level6, t[i].lvl);
        chk($sformatf("%s[%0d].rise",  name, i), rise6,  t[i].rise);
        chk($sformatf("%s[%0d].fall",  name, i), fall6,  t[i].fall);
        chk($sformatf("%s[%0d].busy",  name, i), busy6,  t[i].busy);
      end else begin
        tick(t[i].a, a6);
        chk($sformatf("%s[%0d].level", name, i), level,      t[i].lvl);
        chk($sformatf("%s[%0d].rise",  name, i), rise_pulse, t[i].rise);
        chk($sformatf("%s[%0d].fall",  name, i), fall_pulse, t[i].fall);
        chk($sformatf("%s[%0d].busy",  name, i), busy,       t[i].busy);
      end
    end
  endtask

  // Called just after a posedge; outputs must clear with no clock edge in between.
  task automatic pulse_reset(input string name);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({name, ".level"}, level, 1'b0);
    chk({name, ".rise"},  rise_pulse, 1'b0);
    chk({name, ".fall"},  fall_pulse, 1'b0);
    chk({name, ".busy"},  busy, 1'b0);
    chk({name, ".level6"}, level6, 1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t t_rise[$];
    vec_t t_fall[$];
    vec_t t_glitch[$];
    vec_t t_deb1[$];
    int   rise_cnt;
    int   rise_at;

    // Clean rise: busy after edges 3-5, level and rise_pulse on edge 6.
    t_rise.push_back(mk(1, 0, 0, 0, 0));
    t_rise.push_back(mk(1, 0, 0, 0, 0));
    t_rise.push_back(mk(1, 0, 0, 0, 1));
    t_rise.push_back(mk(1, 0, 0, 0, 1));
    t_rise.push_back(mk(1, 0, 0, 0, 1));
    t_rise.push_back(mk(1, 1, 1, 0, 0));
    t_rise.push_back(mk(1, 1, 0, 0, 0));
    t_rise.push_back(mk(1, 1, 0, 0, 0));
    // Clean fall mirrors the rise.
    t_fall.push_back(mk(0, 1, 0, 0, 0));
    t_fall.push_back(mk(0, 1, 0, 0, 0));
    t_fall.push_back(mk(0, 1, 0, 0, 1));
    t_fall.push_back(mk(0, 1, 0, 0, 1));
    t_fall.push_back(mk(0, 1, 0, 0, 1));
    t_fall.push_back(mk(0, 0, 0, 1, 0));
    t_fall.push_back(mk(0, 0, 0, 0, 0));
    t_fall.push_back(mk(0, 0, 0, 0, 0));
    // Two-cycle glitch: busy for two cycles, no level change.
    t_glitch.push_back(mk(1, 0, 0, 0, 0));
    t_glitch.push_back(mk(1, 0, 0, 0, 0));
    t_glitch.push_back(mk(0, 0, 0, 0, 1));
    t_glitch.push_back(mk(0, 0, 0, 0, 1));
    t_glitch.push_back(mk(0, 0, 0, 0, 0));
    t_glitch.push_back(mk(0, 0, 0, 0, 0));
    // Three-stage synchronizer, single-sample filter: change lands on edge 4.
    t_deb1.push_back(mk(1, 0, 0, 0, 0));
    t_deb1.push_back(mk(1, 0, 0, 0, 0));
    t_deb1.push_back(mk(1, 0, 0, 0, 0));
    t_deb1.push_back(mk(1, 1, 1, 0, 0));
    t_deb1.push_back(mk(1, 1, 0, 0, 0));
    t_deb1.push_back(mk(0, 1, 0, 0, 0));
    t_deb1.push_back(mk(0, 1, 0, 0, 0));
    t_deb1.push_back(mk(0, 1, 0, 0, 0));
    t_deb1.push_back(mk(0, 0, 0, 1, 0));
    t_deb1.push_back(mk(0, 0, 0, 0, 0));

    rst_n    = 1'b1;
    async_in = 1'b0;
    a6       = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset.level", level, 1'b0);
    chk("reset.rise",  rise_pulse, 1'b0);
    chk("reset.fall",  fall_pulse, 1'b0);
    chk("reset.busy",  busy, 1'b0);
    chk("reset.level6", level6, 1'b0);
    chk("reset.rise6",  rise6, 1'b0);
    chk("reset.fall6",  fall6, 1'b0);
    chk("reset.busy6",  busy6, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_table(t_rise,   1'b0, "clean_rise");
    run_table(t_fall,   1'b0, "clean_fall");
    run_table(t_glitch, 1'b0, "glitch");

    // Bounce: 10 alternating samples, then held high; stable run starts at edge 11.
    rise_cnt = 0;
    rise_at  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick((i <= 10) ? (i % 2 == 1) : 1'b1, a6);
      if (rise_pulse) begin
        rise_cnt++;
        rise_at = i;
      end
    end
    chk_int("bounce.rise_count", rise_cnt, 1);
    chk_int("bounce.rise_edge",  rise_at, 16);
    chk("bounce.level", level, 1'b1);

    // Reset while cnt==2, then full latency again after release.
    for (int i = 0; i < 8; i++) tick(1'b0, a6);
    for (int i = 0; i < 4; i++) tick(1'b1, a6);
    chk("midrst.busy_before", busy, 1'b1);
    pulse_reset("midrst");
    rise_cnt = 0;
    rise_at  = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, a6);
      if (rise_pulse) begin
        rise_cnt++;
        rise_at = i;
      end
    end
    chk_int("midrst.rise_count", rise_cnt, 1);
    chk_int("midrst.rise_edge",  rise_at, 6);
    chk("lvl1rst.level_before", level, 1'b1);
    pulse_reset("lvl1rst");

    run_table(t_deb1, 1'b1, "deb1");

    // Randomized run with mixed short bounces and long holds.
    for (int k = 0; k < 400; k++) begin
      bit v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 5));
      if ($urandom_range(0, 99) == 0) pulse_reset("rand_rst");
      for (int j = 0; j < len; j++) tick(v, a6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Conditions one raw asynchronous input (push-button, switch, external strobe) for the core flip-flop fabric.
- Pipeline: multi-stage synchronizer, then a consecutive-sample debounce filter, then a registered edge detector.
- Outputs are clean, glitch-free and clock-domain-safe, so they can drive D-input flip-flops directly.
- Sits directly upstream of the registered logic that consumes `level`, `rise_pulse` and `fall_pulse`.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops. Legal values are 2 or more; elaboration error below 2.
- DEBOUNCE_CYCLES, 50000: consecutive differing synchronized samples needed to accept a new level. Legal values are 1 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1: counter width. Derived internally; not to be overridden.

Ports:
- clk  input  1  single system clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset; on assertion every flop in the block clears immediately.
- async_in  input  1  raw asynchronous input; no timing relationship to clk.
- level  output  1  debounced, synchronized level of async_in.
- rise_pulse  output  1  one-cycle pulse on the cycle level goes 0->1.
- fall_pulse  output  1  one-cycle pulse on the cycle level goes 1->0.
- busy  output  1  high while a candidate level change is being qualified (counter nonzero).

Behaviour:
Reset:
- Reset is asynchronous and active-low, on rst_n, in the single clk domain.
- While rst_n=0, all synchronizer stages, the counter, level, rise_pulse, fall_pulse and busy are 0.
- Release is sampled on the next clk rising edge; no output toggles on release itself.

Synchronizer:
- async_in shifts through SYNC_STAGES flops.
- sync_out is the last stage; it lags async_in by SYNC_STAGES edges.
- No logic is placed between the synchronizer flops.

Filter FSM, two states, encoded by the counter value:
- STABLE (cnt==0):
  - sync_out==level: remain in STABLE.
  - sync_out!=level and DEBOUNCE_CYCLES>1: cnt<=1, go to CHECK.
  - sync_out!=level and DEBOUNCE_CYCLES==1: level<=sync_out immediately, with the matching pulse.
- CHECK (cnt>0):
  - sync_out==level: cnt<=0, back to STABLE. A glitch is rejected and no pulse is produced.
  - sync_out!=level and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - sync_out!=level and cnt==DEBOUNCE_CYCLES-1: level<=~level, cnt<=0, back to STABLE.

Latency:
- A clean step on async_in reaches level after exactly SYNC_STAGES+DEBOUNCE_CYCLES clk edges.
- Edge count is measured from the first edge that samples the new value.

Pulses:
- rise_pulse and fall_pulse are registered and assert on the same edge that updates level.
- Each pulse is high for exactly one cycle.
- Both pulses are never high together.
- A pulse is never produced without a level change.

busy:
- busy is registered and equals (cnt!=0) after each edge.

Counter:
- The counter never exceeds DEBOUNCE_CYCLES-1.
- No wrap-around is possible.

Boundary conditions:
- Input bounce: any return of sync_out to the current level restarts qualification from zero.
- Reset mid-qualification: busy and cnt clear at once. After release, a still-changed input requires the full latency again.
- Reset while level=1: level goes to 0 without asserting fall_pulse.

Test Plan:
Scenarios 1-5 use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
1. Clean rise: async_in 0->1 before edge 1, held high.
   - busy=1 after edges 3-5.
   - level=1 and rise_pulse=1 after edge 6 only; busy=0 after edge 6.
   - fall_pulse stays 0.
2. Glitch rejection: async_in high for 2 cycles then low.
   - busy pulses for 2 cycles.
   - level stays 0; rise_pulse and fall_pulse never assert.
3. Bounce: async_in toggles every cycle for 10 cycles, then holds 1.
   - Exactly one rise_pulse, 6 edges after the final stable sample enters stage 1.
   - level ends at 1.
4. Clean fall: from level=1, async_in 1->0 held.
   - level=0 and fall_pulse=1 exactly 6 edges later, for one cycle.
5. Reset mid-operation: rst_n=0 while cnt=2 with async_in high.
   - busy and level go to 0 immediately, without a clk edge.
   - After release with async_in still 1, rise_pulse appears 6 edges later.
6. DEBOUNCE_CYCLES=1, SYNC_STAGES=3: async_in step.
   - level and rise_pulse after edge 4.
   - busy never asserts.
